word_subtractor_seq: RTL and testbench
======================================

# word_subtractor_seq

Parametrised multi-cycle unsigned subtractor with a start/done handshake. It computes `word_a - word_b - borrow_in` over WIDTH bits, one CHUNK-bit slice per clock, and chains the borrow between slices in a register. It is the sequential, width-generic successor to the byte-wide ripple subtractor. It sits in the datapath wherever wide operands must be subtracted without a full-width ripple chain in one cycle.

## Interface
- `WIDTH`, 32, operand and result width; must be a multiple of CHUNK
- `CHUNK`, 8, bits processed per cycle; NCHUNK = WIDTH/CHUNK, and NCHUNK must be at least 1
- `clk` input 1: single clock, rising edge
- `rst_n` input 1: asynchronous, active-low reset
- `start` input 1: request; sampled only in IDLE
- `word_a` input WIDTH: minuend; captured when start is accepted
- `word_b` input WIDTH: subtrahend; captured when start is accepted
- `borrow_in` input 1: initial borrow; captured when start is accepted
- `busy` output 1: high in RUN and DONE
- `done` output 1: one-cycle pulse; result is valid
- `word_diff` output WIDTH: registered difference
- `borrow_out` output 1: registered final borrow

## Operation
- **FSM states:** IDLE, RUN, DONE.
- **IDLE:**
  - If `start`=1: capture `word_a`, `word_b` and `borrow_in` into internal registers, clear the chunk counter to 0 and go to RUN.
  - Otherwise stay in IDLE.
- **RUN:**
  - Each cycle computes `{b, d} = a[c] - b[c] - borrow_r` on CHUNK bits, where c is the counter value.
  - Writes d into slice c of the result register.
  - Sets `borrow_r` to b and increments the counter.
  - When c = NCHUNK-1, goes to DONE.
- **DONE:**
  - `done`=1 for exactly one cycle.
  - `borrow_out` = final `borrow_r`.
  - Returns to IDLE on the next edge.
- **Arithmetic:** modulo 2^WIDTH. `borrow_out`=1 if and only if `word_a < word_b + borrow_in`, compared as unsigned.
- **Operand inputs:** may change freely after the capture edge; they do not affect a running operation.
- **Start outside IDLE:** `start` in RUN or DONE is ignored, not queued.
- **Result hold:** `word_diff` and `borrow_out` hold their value from DONE until the next accepted start. Slices are overwritten progressively during the next RUN, so they are not guaranteed stable while `busy`=1.
- **Reset, including mid-operation:** all state returns to IDLE. `busy`, `done`, `word_diff`, `borrow_out`, the counter and the internal registers all go to 0. No partial result survives.

## Timing
- **Reset values:** `busy`=0, `done`=0, `word_diff`=0, `borrow_out`=0.
- **Latency:**
  - Start is sampled at edge k.
  - Chunks 0..NCHUNK-1 are processed at edges k+1 .. k+NCHUNK.
  - `done` is high during the cycle after edge k+NCHUNK.
  - `busy` rises after edge k and falls after edge k+NCHUNK+1.
- **Throughput:** one operation per NCHUNK+2 cycles. The earliest next accepted start is at edge k+NCHUNK+2, with `start` held high.
- **Registered outputs:** all outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- **`SUB_SATURATE_EN` defined:** in DONE, if the final borrow is 1, `word_diff` is forced to all zeros (unsigned saturation). `borrow_out` still reports 1.
- **`SUB_SATURATE_EN` undefined:** `word_diff` is the modulo 2^WIDTH result.
- **Timing:** latency is identical in both builds.

## Structure
- **Package `sub_pkg`:**
  - State enum (IDLE/RUN/DONE).
  - A function returning NCHUNK and the counter width, `$clog2` of NCHUNK with a minimum of 1.
- **Sub-module `chunk_subtractor`:**
  - Combinational, parametrised by CHUNK.
  - Ports: `chunk_a`, `chunk_b`, `chunk_borrow_in`, `chunk_diff`, `chunk_borrow_out`.
  - Instantiated once and muxed by the counter.
- **Top level:** holds the FSM, counter, operand and result registers, and the saturation logic.

## Test plan
All cases use WIDTH=32, CHUNK=8.
- **Simple difference:** a=0x00000005, b=0x00000003, bin=0 -> `done` 4 edges after the start edge; diff=0x00000002, bout=0.
- **Cross-chunk borrow:** a=0x00000100, b=0x00000001, bin=0 -> diff=0x000000FF, bout=0. Borrow ripples across the chunk 0→1 boundary.
- **Underflow:** a=0, b=1, bin=0 -> diff=0xFFFFFFFF, bout=1. With `SUB_SATURATE_EN` defined: diff=0x00000000, bout=1.
- **Borrow in:** a=0x00000010, b=0x0000000F, bin=1 -> diff=0x00000000, bout=0.
- **Start while busy:**
  - Pulse start with a=7, b=2, then pulse start with a=9, b=9 during RUN -> only diff=0x00000005 is produced, and exactly one `done` pulse.
  - Operands changed after capture have no effect.
- **Reset mid-RUN:** deassert `rst_n` after 2 chunks -> all outputs 0 immediately; a subsequent start with a=0xFFFFFFFF, b=0x12345678 gives diff=0xEDCBA987, bout=0.

Source files
------------

// File: rtl/sub_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sub_pkg
//  Description : Shared types and sizing helpers for the sequential word
//                subtractor. The FSM state encoding, the chunk count and the
//                width of the chunk counter are all defined here.
//  Revision    : 1.0 - initial release
// ============================================================================
package sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Number of CHUNK-bit slices in a WIDTH-bit word.
    function automatic int calc_nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Counter width. A single-chunk configuration still gets a 1-bit counter
    // so that no zero-width vector is ever declared.
    function automatic int calc_cnt_width(input int nchunk);
        return (nchunk <= 1) ? 1 : $clog2(nchunk);
    endfunction

endpackage : sub_pkg
`default_nettype wire

// File: rtl/chunk_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : chunk_subtractor
//  Description : Combinational CHUNK-bit subtractor with borrow in/out.
//                {chunk_borrow_out, chunk_diff} = chunk_a - chunk_b
//                                                 - chunk_borrow_in
//  Ports       : chunk_a          - minuend slice
//                chunk_b          - subtrahend slice
//                chunk_borrow_in  - borrow from the previous (lower) slice
//                chunk_diff       - difference slice
//                chunk_borrow_out - borrow into the next (higher) slice
//  Revision    : 1.0 - initial release
// ============================================================================
module chunk_subtractor #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] chunk_a,
    input  logic [CHUNK-1:0] chunk_b,
    input  logic             chunk_borrow_in,
    output logic [CHUNK-1:0] chunk_diff,
    output logic             chunk_borrow_out
);

    // One extra bit on the left catches the borrow: when the true result is
    // negative, the two's-complement wrap sets bit CHUNK.
    logic [CHUNK:0] w_full;

    assign w_full           = {1'b0, chunk_a} - {1'b0, chunk_b}
                              - {{CHUNK{1'b0}}, chunk_borrow_in};
    assign chunk_diff       = w_full[CHUNK-1:0];
    assign chunk_borrow_out = w_full[CHUNK];

endmodule : chunk_subtractor
`default_nettype wire

// File: rtl/word_subtractor_seq.sv
`default_nettype none
// ============================================================================
//  Module      : word_subtractor_seq
//  Description : Multi-cycle unsigned subtractor, word_a - word_b - borrow_in
//                over WIDTH bits, one CHUNK-bit slice per clock with the
//                borrow chained through a register. Start/done handshake.
//  Ports       : clk, rst_n       - clock, asynchronous active-low reset
//                start            - request, sampled only in IDLE
//                word_a, word_b   - operands, captured on accepted start
//                borrow_in        - initial borrow, captured on accepted start
//                busy             - high in RUN and DONE
//                done             - one-cycle pulse, result valid
//                word_diff        - registered difference
//                borrow_out       - registered final borrow
//  Options     : SUB_SATURATE_EN  - when defined, a final borrow of 1 forces
//                                   word_diff to zero (borrow_out still 1)
//  Revision    : 1.0 - initial release
// ============================================================================
module word_subtractor_seq
    import sub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] word_a,
    input  logic [WIDTH-1:0] word_b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] word_diff,
    output logic             borrow_out
);

    localparam int                 c_NCHUNK = calc_nchunk(WIDTH, CHUNK);
    localparam int                 c_CNT_W  = calc_cnt_width(c_NCHUNK);
    localparam logic [c_CNT_W-1:0] c_LAST   = c_CNT_W'(c_NCHUNK - 1);

    generate
        if ((WIDTH % CHUNK) != 0 || WIDTH < CHUNK) begin : g_bad_params
            $error("word_subtractor_seq: WIDTH must be a non-zero multiple of CHUNK");
        end
    endgenerate

    state_t             r_state;
    state_t             w_state_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_borrow;
    logic [WIDTH-1:0]   r_diff;
    logic               r_borrow_out;
    logic               r_busy;
    logic               r_done;

    int                 w_base;
    logic               w_last;
    logic [CHUNK-1:0]   w_chunk_a;
    logic [CHUNK-1:0]   w_chunk_b;
    logic [CHUNK-1:0]   w_chunk_diff;
    logic               w_chunk_bout;

    // ------------------------------------------------------------------
    // Slice select: a single subtractor shared across all chunks.
    // ------------------------------------------------------------------
    assign w_base    = int'(r_cnt) * CHUNK;
    assign w_last    = (r_cnt == c_LAST);
    assign w_chunk_a = r_a[w_base +: CHUNK];
    assign w_chunk_b = r_b[w_base +: CHUNK];

    chunk_subtractor #(
        .CHUNK (CHUNK)
    ) u_chunk_sub (
        .chunk_a          (w_chunk_a),
        .chunk_b          (w_chunk_b),
        .chunk_borrow_in  (r_borrow),
        .chunk_diff       (w_chunk_diff),
        .chunk_borrow_out (w_chunk_bout)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start)  w_state_next = ST_RUN;
            ST_RUN:  if (w_last) w_state_next = ST_DONE;
            ST_DONE:             w_state_next = ST_IDLE;
            default:             w_state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State, datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_borrow     <= 1'b0;
            r_diff       <= '0;
            r_borrow_out <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state <= w_state_next;
            // busy/done are decoded from the next state so that they are
            // plain flops aligned with the state register.
            r_busy  <= (w_state_next != ST_IDLE);
            r_done  <= (w_state_next == ST_DONE);

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a      <= word_a;
                        r_b      <= word_b;
                        r_borrow <= borrow_in;
                        r_cnt    <= '0;
                    end
                end
                ST_RUN: begin
                    r_diff[w_base +: CHUNK] <= w_chunk_diff;
                    r_borrow                <= w_chunk_bout;
                    if (w_last) begin
                        r_cnt        <= '0;
                        r_borrow_out <= w_chunk_bout;
`ifdef SUB_SATURATE_EN
                        // Final borrow known on this edge: clamp the whole
                        // word now so DONE already shows the saturated value.
                        if (w_chunk_bout) begin
                            r_diff <= '0;
                        end
`endif
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign word_diff  = r_diff;
    assign borrow_out = r_borrow_out;

endmodule : word_subtractor_seq
`default_nettype wire

// File: tb/tb_word_subtractor_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_word_subtractor_seq
//  Description : Self-checking bench for word_subtractor_seq (WIDTH=32,
//                CHUNK=8). Directed vectors push expected results into a
//                scoreboard queue; a monitor pops and compares on each done.
//                Honours SUB_SATURATE_EN for the expected values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_word_subtractor_seq;

    localparam int WIDTH  = 32;
    localparam int CHUNK  = 8;
    localparam int NCHUNK = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] word_a = '0;
    logic [WIDTH-1:0] word_b = '0;
    logic             borrow_in = 1'b0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] word_diff;
    logic             borrow_out;

    typedef struct packed {
        logic [WIDTH-1:0] diff;
        logic             bout;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    word_subtractor_seq #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .word_a     (word_a),
        .word_b     (word_b),
        .borrow_in  (borrow_in),
        .busy       (busy),
        .done       (done),
        .word_diff  (word_diff),
        .borrow_out (borrow_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Modulo expectation, clamped when the saturating build is selected.
    function automatic logic [WIDTH-1:0] adj(input logic [WIDTH-1:0] d, input logic b);
`ifdef SUB_SATURATE_EN
        return b ? '0 : d;
`else
        return (b === 1'b1) ? d : d;
`endif
    endfunction

    task automatic run_op(input string name, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic bin,
                          input logic [WIDTH-1:0] exp_d, input logic exp_b);
        int   edges;
        logic got;
        logic [WIDTH-1:0] d;
        d = adj(exp_d, exp_b);
        @(negedge clk);
        word_a    = a;
        word_b    = b;
        borrow_in = bin;
        start     = 1'b1;
        sb_q.push_back('{diff: d, bout: exp_b});
        @(posedge clk);
        #1;
        start     = 1'b0;
        // Scramble operands after capture; they must not matter.
        word_a    = ~a;
        word_b    = a ^ 32'h5A5A_5A5A;
        borrow_in = ~bin;
        check({name, "_busy_rise"}, 64'(busy), 64'd1);
        edges = 0;
        got   = 1'b0;
        while (!got && edges < 12) begin
            @(posedge clk);
            #1;
            edges++;
            if (done === 1'b1) got = 1'b1;
        end
        check({name, "_latency"}, 64'(edges), 64'(NCHUNK));
        @(posedge clk);
        #1;
        check({name, "_busy_fall"}, 64'(busy), 64'd0);
        check({name, "_done_pulse"}, 64'(done), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        check({name, "_hold_diff"}, 64'(word_diff), 64'(d));
        check({name, "_hold_bout"}, 64'(borrow_out), 64'(exp_b));
    endtask

    initial begin
        fork
            begin : monitor
                exp_t e;
                forever begin
                    @(negedge clk);
                    if (done === 1'b1) begin
                        if (sb_q.size() == 0) begin
                            n_checks++;
                            n_errors++;
                            $display("FAIL unexpected_done: got done=1 with diff=0x%0h, expected no pending result",
                                     word_diff);
                        end else begin
                            e = sb_q.pop_front();
                            check("sb_diff", 64'(word_diff), 64'(e.diff));
                            check("sb_bout", 64'(borrow_out), 64'(e.bout));
                        end
                    end
                end
            end
            begin : stimulus
                int n_done;
                // Reset state
                repeat (2) @(posedge clk);
                #1;
                check("rst_busy", 64'(busy), 64'd0);
                check("rst_done", 64'(done), 64'd0);
                check("rst_diff", 64'(word_diff), 64'd0);
                check("rst_bout", 64'(borrow_out), 64'd0);
                @(negedge clk);
                rst_n = 1'b1;

                run_op("simple",  32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0);
                run_op("xchunk",  32'h0000_0100, 32'h0000_0001, 1'b0, 32'h0000_00FF, 1'b0);
                run_op("under",   32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1);
                run_op("bin",     32'h0000_0010, 32'h0000_000F, 1'b1, 32'h0000_0000, 1'b0);
                run_op("maxb",    32'h1234_5678, 32'hFFFF_FFFF, 1'b1, 32'h1234_5678, 1'b1);
                run_op("maxa",    32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 32'hFFFF_FFFF, 1'b0);
                run_op("eqbin",   32'h8000_0000, 32'h8000_0000, 1'b1, 32'hFFFF_FFFF, 1'b1);

                // Start while busy: second request during RUN is dropped.
                @(negedge clk);
                word_a = 32'd7; word_b = 32'd2; borrow_in = 1'b0; start = 1'b1;
                sb_q.push_back('{diff: 32'd5, bout: 1'b0});
                @(posedge clk);
                #1;
                start = 1'b0;
                @(negedge clk);
                word_a = 32'd9; word_b = 32'd9; start = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
                n_done = 0;
                repeat (14) begin
                    @(posedge clk);
                    #1;
                    if (done === 1'b1) n_done++;
                end
                check("busy_start_ndone", 64'(n_done), 64'd1);
                check("busy_start_diff", 64'(word_diff), 64'd5);
                check("busy_start_idle", 64'(busy), 64'd0);

                // Reset in the middle of RUN, after two chunks.
                @(negedge clk);
                word_a = 32'hAAAA_AAAA; word_b = 32'h1111_1111; start = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
                repeat (2) @(posedge clk);
                #2;
                rst_n = 1'b0;
                #1;
                check("midrst_busy", 64'(busy), 64'd0);
                check("midrst_done", 64'(done), 64'd0);
                check("midrst_diff", 64'(word_diff), 64'd0);
                check("midrst_bout", 64'(borrow_out), 64'd0);
                @(negedge clk);
                rst_n = 1'b1;
                run_op("postrst", 32'hFFFF_FFFF, 32'h1234_5678, 1'b0, 32'hEDCB_A987, 1'b0);

                repeat (5) @(posedge clk);
                #1;
                check("sb_empty", 64'(sb_q.size()), 64'd0);
            end
        join_any
        disable fork;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_word_subtractor_seq
`default_nettype wire
